edf_arbiter: RTL and testbench



---
 rtl/edf_arbiter_if.sv | 27 ++
 rtl/edf_arbiter.sv | 120 ++++++++++++
 tb/tb_edf_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/edf_arbiter_if.sv
// Gateway/core-facing bundle of the EDF arbiter: pending flags and deadlines in,
// claimed winner and clear pulse out.
interface edf_arbiter_if #(
   parameter int NrSrc   = 8,
   parameter int TsWidth = 64
);
   localparam int IdWidth = $clog2(NrSrc);

   logic                            enable_i;
   logic [NrSrc-1:0]                ip_i;
   logic [NrSrc-1:0][TsWidth-1:0]   dl_i;
   logic                            claim_i;
   logic                            irq_valid_o;
   logic [IdWidth-1:0]              irq_id_o;
   logic [TsWidth-1:0]              irq_dl_o;
   logic [NrSrc-1:0]                clear_o;

   modport master (
      output enable_i, ip_i, dl_i, claim_i,
      input  irq_valid_o, irq_id_o, irq_dl_o, clear_o
   );

   modport slave (
      input  enable_i, ip_i, dl_i, claim_i,
      output irq_valid_o, irq_id_o, irq_dl_o, clear_o
   );
endinterface

// File: rtl/edf_arbiter.sv
// Earliest-deadline-first selector: scans one source per cycle, commits the
// smallest pending deadline every NrSrc+1 cycles and handles the claim/clear.
module edf_arbiter #(
   parameter int NrSrc   = 8,
   parameter int TsWidth = 64
) (
   input logic          clk_i,
   input logic          rst_i,
   edf_arbiter_if.slave bus
);
   localparam int IdWidth = $clog2(NrSrc);

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_e;

   state_e               state_q, state_d;
   logic [IdWidth-1:0]   idx_q, idx_d;
   logic                 found_q, found_d;
   logic [IdWidth-1:0]   best_id_q, best_id_d;
   logic [TsWidth-1:0]   best_dl_q, best_dl_d;
   logic [NrSrc-1:0]     mask_q, mask_d;
   logic                 valid_q, valid_d;
   logic [IdWidth-1:0]   id_q, id_d;
   logic [TsWidth-1:0]   dl_q, dl_d;
   logic [NrSrc-1:0]     clear_q, clear_d;

   logic take, last, claim_ok;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      found_d   = found_q;
      best_id_d = best_id_q;
      best_dl_d = best_dl_q;
      mask_d    = mask_q;
      valid_d   = valid_q;
      id_d      = id_q;
      dl_d      = dl_q;
      clear_d   = '0;

      last     = (idx_q == IdWidth'(NrSrc-1));
      // found is always cleared on entry to idx 0, so it only reflects this pass
      take     = bus.ip_i[idx_q] && !mask_q[idx_q] &&
                 (!found_q || (bus.dl_i[idx_q] < best_dl_q));
      claim_ok = bus.claim_i && valid_q && (state_q != IDLE);

      if (!bus.enable_i) begin
         state_d = IDLE;
         idx_d   = '0;
         found_d = 1'b0;
         mask_d  = '0;
         valid_d = 1'b0;
      end else if (claim_ok) begin
         // Claim beats a coincident COMMIT: clear the presented id and rescan without it
         clear_d = NrSrc'(1) << id_q;
         mask_d  = NrSrc'(1) << id_q;
         valid_d = 1'b0;
         state_d = SCAN;
         idx_d   = '0;
         found_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = SCAN;
               idx_d   = '0;
               found_d = 1'b0;
            end
            SCAN: begin
               if (take) begin
                  found_d   = 1'b1;
                  best_id_d = idx_q;
                  best_dl_d = bus.dl_i[idx_q];
               end
               if (last) state_d = COMMIT;
               else      idx_d   = idx_q + 1'b1;
            end
            COMMIT: begin
               valid_d = found_q && bus.ip_i[best_id_q];
               id_d    = best_id_q;
               dl_d    = best_dl_q;
               mask_d  = '0;
               state_d = SCAN;
               idx_d   = '0;
               found_d = 1'b0;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         found_q   <= 1'b0;
         best_id_q <= '0;
         best_dl_q <= '0;
         mask_q    <= '0;
         valid_q   <= 1'b0;
         id_q      <= '0;
         dl_q      <= '0;
         clear_q   <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         found_q   <= found_d;
         best_id_q <= best_id_d;
         best_dl_q <= best_dl_d;
         mask_q    <= mask_d;
         valid_q   <= valid_d;
         id_q      <= id_d;
         dl_q      <= dl_d;
         clear_q   <= clear_d;
      end
   end

   assign bus.irq_valid_o = valid_q;
   assign bus.irq_id_o    = id_q;
   assign bus.irq_dl_o    = dl_q;
   assign bus.clear_o     = clear_q;
endmodule

// File: tb/tb_edf_arbiter.sv
// Directed bench for edf_arbiter: steady-state vector table plus hand-timed
// claim, claim-at-COMMIT, stale-winner and mid-scan reset sequences.
module tb_edf_arbiter;
   localparam int NrSrc   = 8;
   localparam int TsWidth = 64;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   edf_arbiter_if #(.NrSrc(NrSrc), .TsWidth(TsWidth)) bus ();

   edf_arbiter #(.NrSrc(NrSrc), .TsWidth(TsWidth)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NrSrc-1:0]              ip;
      logic [NrSrc-1:0][TsWidth-1:0] dl;
      logic                          exp_v;
      logic                          chk_id;
      logic [2:0]                    exp_id;
      logic [TsWidth-1:0]            exp_dl;
   } vec_t;

   vec_t vecs [8];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic v, input logic [2:0] id, input logic [63:0] dl);
      chk({nm, "_valid"}, 64'(bus.irq_valid_o), 64'(v));
      chk({nm, "_id"},    64'(bus.irq_id_o),    64'(id));
      chk({nm, "_dl"},    bus.irq_dl_o,         dl);
   endtask

   initial begin
      int   n;
      logic bad;

      for (int i = 0; i < 8; i++) begin
         vecs[i].dl     = '0;
         vecs[i].chk_id = 1'b1;
         vecs[i].exp_v  = 1'b1;
      end
      // min select
      vecs[0].ip = 8'b1010_0110;
      vecs[0].dl[1] = 64'd50; vecs[0].dl[2] = 64'd30; vecs[0].dl[5] = 64'd30; vecs[0].dl[7] = 64'd10;
      vecs[0].exp_id = 3'd7; vecs[0].exp_dl = 64'd10;
      // tie goes to lower index
      vecs[1] = vecs[0]; vecs[1].ip = 8'b0010_0110; vecs[1].exp_id = 3'd2; vecs[1].exp_dl = 64'd30;
      // nothing pending
      vecs[2].ip = 8'h00; vecs[2].exp_v = 1'b0; vecs[2].chk_id = 1'b0;
      vecs[2].exp_id = 3'd0; vecs[2].exp_dl = '0;
      // all equal deadlines
      vecs[3].ip = 8'hFF;
      for (int k = 0; k < NrSrc; k++) vecs[3].dl[k] = 64'd77;
      vecs[3].exp_id = 3'd0; vecs[3].exp_dl = 64'd77;
      // full-width unsigned extremes
      vecs[4].ip = 8'b1000_0001;
      vecs[4].dl[0] = '1; vecs[4].dl[7] = 64'hFFFF_FFFF_FFFF_FFFE;
      vecs[4].exp_id = 3'd7; vecs[4].exp_dl = 64'hFFFF_FFFF_FFFF_FFFE;
      // upper-word decides
      vecs[5].ip = 8'b1100_0000;
      vecs[5].dl[6] = 64'h1_0000_0000; vecs[5].dl[7] = 64'h0_FFFF_FFFF;
      vecs[5].exp_id = 3'd7; vecs[5].exp_dl = 64'h0_FFFF_FFFF;
      // later-scanned smaller replaces earlier
      vecs[6].ip = 8'b0000_0011;
      vecs[6].dl[0] = 64'd5; vecs[6].dl[1] = 64'd4;
      vecs[6].exp_id = 3'd1; vecs[6].exp_dl = 64'd4;
      // leaves id 2 presented for the claim sequence
      vecs[7] = vecs[1];

      rst = 1'b1;
      bus.enable_i = 1'b0; bus.ip_i = '0; bus.dl_i = '0; bus.claim_i = 1'b0;
      tick(2);
      chk_out("reset", 1'b0, 3'd0, 64'd0);
      chk("reset_clear", 64'(bus.clear_o), 64'd0);

      rst = 1'b0;
      bus.ip_i = 8'hFF;
      bus.dl_i = vecs[3].dl;
      bus.claim_i = 1'b1;
      bad = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick(1);
         if (bus.clear_o != '0 || bus.irq_valid_o) bad = 1'b1;
      end
      bus.claim_i = 1'b0;
      chk("idle_quiet", 64'(bad), 64'd0);
      chk("idle_id", 64'(bus.irq_id_o), 64'd0);

      // single source, enable to first presented winner
      bus.ip_i = 8'b0010_0000;
      bus.dl_i = '0; bus.dl_i[5] = 64'd100;
      bus.enable_i = 1'b1;
      n = 0;
      while (!bus.irq_valid_o && n < 17) begin
         tick(1);
         n++;
      end
      chk("single_latency", 64'(n), 64'd10);
      chk_out("single", 1'b1, 3'd5, 64'd100);

      for (int i = 0; i < 8; i++) begin
         bus.ip_i = vecs[i].ip;
         bus.dl_i = vecs[i].dl;
         tick(2 * (NrSrc + 1));
         chk($sformatf("vec%0d_valid", i), 64'(bus.irq_valid_o), 64'(vecs[i].exp_v));
         if (vecs[i].chk_id) begin
            chk($sformatf("vec%0d_id", i), 64'(bus.irq_id_o), 64'(vecs[i].exp_id));
            chk($sformatf("vec%0d_dl", i), bus.irq_dl_o, vecs[i].exp_dl);
         end
      end

      // claim id 2; its ip stays high through the rescan so only the mask hides it
      bus.claim_i = 1'b1;
      tick(1);
      bus.claim_i = 1'b0;
      chk("claim_clear", 64'(bus.clear_o), 64'h04);
      chk("claim_valid_drop", 64'(bus.irq_valid_o), 64'd0);
      tick(1);
      chk("claim_clear_1cyc", 64'(bus.clear_o), 64'd0);
      tick(7);
      chk("claim_restart_v", 64'(bus.irq_valid_o), 64'd0);
      tick(1);
      chk_out("claim_masked", 1'b1, 3'd5, 64'd30);
      tick(NrSrc + 1);
      chk_out("mask_release", 1'b1, 3'd2, 64'd30);

      // claim in the COMMIT cycle that would present id 7
      bus.ip_i = 8'b1010_0110;
      bus.dl_i[7] = 64'd10;
      tick(NrSrc);
      bus.claim_i = 1'b1;
      tick(1);
      bus.claim_i = 1'b0;
      bus.ip_i = 8'b1010_0010;
      chk("cc_clear_old", 64'(bus.clear_o), 64'h04);
      chk_out("cc_discard", 1'b0, 3'd2, 64'd30);
      tick(NrSrc);
      chk("cc_full_scan", 64'(bus.irq_valid_o), 64'd0);
      tick(1);
      chk_out("cc_winner", 1'b1, 3'd7, 64'd10);

      // winner's ip drops after it was scanned
      tick(NrSrc);
      bus.ip_i = 8'b0010_0010;
      tick(1);
      chk_out("stale", 1'b0, 3'd7, 64'd10);
      bus.ip_i = 8'b1010_0010;
      tick(NrSrc + 1);
      chk_out("stale_recover", 1'b1, 3'd7, 64'd10);

      // reset while idx=4, with a claim that must not produce a clear
      tick(4);
      rst = 1'b1;
      bus.claim_i = 1'b1;
      tick(1);
      chk_out("rst_mid", 1'b0, 3'd0, 64'd0);
      chk("rst_mid_clear", 64'(bus.clear_o), 64'd0);
      rst = 1'b0;
      bus.claim_i = 1'b0;
      tick(NrSrc + 1);
      chk("rst_via_idle", 64'(bus.irq_valid_o), 64'd0);
      tick(1);
      chk_out("rst_restart", 1'b1, 3'd7, 64'd10);

      bus.enable_i = 1'b0;
      tick(1);
      chk("en_off_valid", 64'(bus.irq_valid_o), 64'd0);
      bus.claim_i = 1'b1;
      tick(1);
      chk("en_off_claim", 64'(bus.clear_o), 64'd0);
      bus.claim_i = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
